// File: rtl/anycore_l15_pkg.sv
// Shared AnyCore <-> L1.5 definitions: request/return type codes, cache geometry
// and the big-endian to little-endian word byte swap.
package anycore_l15_pkg;

    localparam int unsigned PHY_ADDR_WIDTH         = 40;
    localparam int unsigned ICACHE_BLOCK_ADDR_BITS = 35;
    localparam int unsigned DCACHE_BLOCK_ADDR_BITS = 35;
    localparam int unsigned LINE_OFFSET_BITS       = 5;

    localparam logic [3:0] LOAD_RET  = 4'b0000;
    localparam logic [3:0] IFILL_RET = 4'b0001;
    localparam logic [3:0] INV_RET   = 4'b0011;
    localparam logic [3:0] ST_ACK    = 4'b0100;
    localparam logic [3:0] INT_RET   = 4'b0111;

    localparam logic [4:0] LOAD_RQ   = 5'b00000;
    localparam logic [4:0] STORE_RQ  = 5'b00001;
    localparam logic [4:0] IMISS_RQ  = 5'b10000;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_IM,
        REQ_LD,
        REQ_ST
    } req_class_e;

    function automatic req_class_e classify_rq(input logic [4:0] rqtype);
        case (rqtype)
            IMISS_RQ: return REQ_IM;
            LOAD_RQ:  return REQ_LD;
            STORE_RQ: return REQ_ST;
            default:  return REQ_NONE;
        endcase
    endfunction

    function automatic logic [63:0] bswap64(input logic [63:0] w);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            r[8*i +: 8] = w[8*(7-i) +: 8];
        end
        return r;
    endfunction

    function automatic logic [255:0] bswap_line(input logic [255:0] line);
        logic [255:0] r;
        r = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            r[64*i +: 64] = bswap64(line[64*i +: 64]);
        end
        return r;
    endfunction

endpackage

// File: rtl/anycore_req_tracker.sv
// One-outstanding-request tracker per class (imiss/load/store) with block address capture.
// Optional protocol checker built only when ANYCORE_RESP_ERR_CHK_EN is defined.
module anycore_req_tracker
    import anycore_l15_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cap_val,
    input  logic [4:0]                        cap_rqtype,
    input  logic [PHY_ADDR_WIDTH-1:0]         cap_address,
    input  logic                              ret_im,
    input  logic                              ret_ld,
    input  logic                              ret_st,
    output logic                              pend_im,
    output logic                              pend_ld,
    output logic                              pend_st,
    output logic [ICACHE_BLOCK_ADDR_BITS-1:0] im_addr,
    output logic [DCACHE_BLOCK_ADDR_BITS-1:0] ld_addr,
    output logic                              resp_err
);

    req_class_e cap_class;
    logic cap_im, cap_ld, cap_st;

    logic pend_im_q, pend_im_d;
    logic pend_ld_q, pend_ld_d;
    logic pend_st_q, pend_st_d;
    logic [ICACHE_BLOCK_ADDR_BITS-1:0] im_addr_q, im_addr_d;
    logic [DCACHE_BLOCK_ADDR_BITS-1:0] ld_addr_q, ld_addr_d;

    logic unused_addr_bits;
    assign unused_addr_bits = ^cap_address[LINE_OFFSET_BITS-1:0];

    always_comb begin
        cap_class = cap_val ? classify_rq(cap_rqtype) : REQ_NONE;
        cap_im    = (cap_class == REQ_IM);
        cap_ld    = (cap_class == REQ_LD);
        cap_st    = (cap_class == REQ_ST);
    end

    // A capture wins over a same-cycle return, so the flag stays set for the new request.
    always_comb begin
        pend_im_d = cap_im ? 1'b1 : (ret_im ? 1'b0 : pend_im_q);
        pend_ld_d = cap_ld ? 1'b1 : (ret_ld ? 1'b0 : pend_ld_q);
        pend_st_d = cap_st ? 1'b1 : (ret_st ? 1'b0 : pend_st_q);
        im_addr_d = im_addr_q;
        ld_addr_d = ld_addr_q;
        if (cap_im) im_addr_d = cap_address[ICACHE_BLOCK_ADDR_BITS+LINE_OFFSET_BITS-1:LINE_OFFSET_BITS];
        if (cap_ld) ld_addr_d = cap_address[DCACHE_BLOCK_ADDR_BITS+LINE_OFFSET_BITS-1:LINE_OFFSET_BITS];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_im_q <= 1'b0;
            pend_ld_q <= 1'b0;
            pend_st_q <= 1'b0;
            im_addr_q <= '0;
            ld_addr_q <= '0;
        end else begin
            pend_im_q <= pend_im_d;
            pend_ld_q <= pend_ld_d;
            pend_st_q <= pend_st_d;
            im_addr_q <= im_addr_d;
            ld_addr_q <= ld_addr_d;
        end
    end

    assign pend_im = pend_im_q;
    assign pend_ld = pend_ld_q;
    assign pend_st = pend_st_q;
    assign im_addr = im_addr_q;
    assign ld_addr = ld_addr_q;

`ifdef ANYCORE_RESP_ERR_CHK_EN
    logic resp_err_q, resp_err_d;
    logic unexpected_ret, double_cap;

    always_comb begin
        unexpected_ret = (ret_im & ~pend_im_q) | (ret_ld & ~pend_ld_q) | (ret_st & ~pend_st_q);
        double_cap     = (cap_im & pend_im_q & ~ret_im) |
                         (cap_ld & pend_ld_q & ~ret_ld) |
                         (cap_st & pend_st_q & ~ret_st);
        resp_err_d     = resp_err_q | unexpected_ret | double_cap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) resp_err_q <= 1'b0;
        else     resp_err_q <= resp_err_d;
    end

    assign resp_err = resp_err_q;
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: rtl/anycore_resp_encoder.sv
// L1.5 return packets -> AnyCore mem2ic/mem2dc completion pulses with byte-swapped lines.
// Optional protocol checker enabled by defining ANYCORE_RESP_ERR_CHK_EN.
module anycore_resp_encoder
    import anycore_l15_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              dec_l15_val,
    input  logic [4:0]                        dec_l15_rqtype,
    input  logic [PHY_ADDR_WIDTH-1:0]         dec_l15_address,
    input  logic                              l15_dec_ack,
    input  logic                              l15_resp_val,
    input  logic [3:0]                        l15_resp_returntype,
    input  logic [255:0]                      l15_resp_data,
    output logic                              l15_resp_ack,
    output logic                              mem2ic_comp,
    output logic [ICACHE_BLOCK_ADDR_BITS-1:0] mem2ic_index,
    output logic [255:0]                      mem2ic_data,
    output logic                              mem2dc_ldcomp,
    output logic [DCACHE_BLOCK_ADDR_BITS-1:0] mem2dc_ldindex,
    output logic [255:0]                      mem2dc_lddata,
    output logic                              mem2dc_stcomp,
    output logic                              resp_err
);

    logic ret_im, ret_ld, ret_st;
    logic pend_im, pend_ld, pend_st;
    logic [ICACHE_BLOCK_ADDR_BITS-1:0] im_addr;
    logic [DCACHE_BLOCK_ADDR_BITS-1:0] ld_addr;
    logic [255:0] swapped;

    logic                              ic_comp_q, ic_comp_d;
    logic [ICACHE_BLOCK_ADDR_BITS-1:0] ic_index_q, ic_index_d;
    logic [255:0]                      ic_data_q, ic_data_d;
    logic                              ld_comp_q, ld_comp_d;
    logic [DCACHE_BLOCK_ADDR_BITS-1:0] ld_index_q, ld_index_d;
    logic [255:0]                      ld_data_q, ld_data_d;
    logic                              st_comp_q, st_comp_d;

    assign l15_resp_ack = l15_resp_val;

    always_comb begin
        ret_im  = l15_resp_val & (l15_resp_returntype == IFILL_RET);
        ret_ld  = l15_resp_val & (l15_resp_returntype == LOAD_RET);
        ret_st  = l15_resp_val & (l15_resp_returntype == ST_ACK);
        swapped = bswap_line(l15_resp_data);
    end

    anycore_req_tracker u_tracker (
        .clk         (clk),
        .rst         (rst),
        .cap_val     (dec_l15_val & l15_dec_ack),
        .cap_rqtype  (dec_l15_rqtype),
        .cap_address (dec_l15_address),
        .ret_im      (ret_im),
        .ret_ld      (ret_ld),
        .ret_st      (ret_st),
        .pend_im     (pend_im),
        .pend_ld     (pend_ld),
        .pend_st     (pend_st),
        .im_addr     (im_addr),
        .ld_addr     (ld_addr),
        .resp_err    (resp_err)
    );

    logic unused_pend;
    assign unused_pend = pend_im ^ pend_ld ^ pend_st;

    // Index comes from the registered capture, i.e. the old address on a same-cycle capture.
    always_comb begin
        ic_comp_d  = ret_im;
        ld_comp_d  = ret_ld;
        st_comp_d  = ret_st;
        ic_index_d = ret_im ? im_addr : ic_index_q;
        ic_data_d  = ret_im ? swapped : ic_data_q;
        ld_index_d = ret_ld ? ld_addr : ld_index_q;
        ld_data_d  = ret_ld ? swapped : ld_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ic_comp_q  <= 1'b0;
            ic_index_q <= '0;
            ic_data_q  <= '0;
            ld_comp_q  <= 1'b0;
            ld_index_q <= '0;
            ld_data_q  <= '0;
            st_comp_q  <= 1'b0;
        end else begin
            ic_comp_q  <= ic_comp_d;
            ic_index_q <= ic_index_d;
            ic_data_q  <= ic_data_d;
            ld_comp_q  <= ld_comp_d;
            ld_index_q <= ld_index_d;
            ld_data_q  <= ld_data_d;
            st_comp_q  <= st_comp_d;
        end
    end

    assign mem2ic_comp    = ic_comp_q;
    assign mem2ic_index   = ic_index_q;
    assign mem2ic_data    = ic_data_q;
    assign mem2dc_ldcomp  = ld_comp_q;
    assign mem2dc_ldindex = ld_index_q;
    assign mem2dc_lddata  = ld_data_q;
    assign mem2dc_stcomp  = st_comp_q;

endmodule
